// File: rtl/div_unit.sv
// Multicycle 32-bit restoring divider for MIPS div: 33-cycle latency, HI=remainder, LO=quotient.
// Optional DIV_DIVU_EN adds a divu input selecting unsigned operation.
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef DIV_DIVU_EN
  input  logic        divu,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [31:0] rem, quo, dvsr;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;

  logic        uns_in;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic        start_ok, start_dz;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] rem_nxt;

`ifdef DIV_DIVU_EN
  assign uns_in = divu;
`else
  assign uns_in = 1'b0;
`endif

  // Magnitude of 0x80000000 is 0x80000000 read as unsigned, so the overflow case wraps naturally.
  assign a_neg    = !uns_in && A[31];
  assign b_neg    = !uns_in && B[31];
  assign a_abs    = a_neg ? -A : A;
  assign b_abs    = b_neg ? -B : B;
  assign start_ok = (state == IDLE) && start && (B != 32'd0);
  assign start_dz = (state == IDLE) && start && (B == 32'd0);

  // Shifted remainder needs 33 bits when an unsigned divisor exceeds 2^31.
  assign sh      = {rem, quo[31]};
  assign ge      = (sh >= {1'b0, dvsr});
  assign rem_nxt = ge ? (sh[31:0] - dvsr) : sh[31:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = CALC;
      CALC:    if (cnt == 5'd0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= (state == FIX);
      div_zero <= start_dz;
      case (state)
        IDLE: if (start_ok) begin
          rem   <= '0;
          quo   <= a_abs;
          dvsr  <= b_abs;
          cnt   <= 5'd31;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= {quo[30:0], ge};
          cnt <= cnt - 5'd1;
        end
        FIX: begin
          lo <= neg_q ? -quo : quo;
          hi <= neg_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule
